// File: rtl/serial_mult3_tx.sv
// Serial source for the divisible-by-3 link: accepts a word, sends word*3 MSB-first,
// framing each product and tracking its running mod-3 remainder as a self-check.
module serial_mult3_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             tx_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic [1:0]       rem_out,
    output logic             frame_err,
    output logic             busy
);
    localparam int OUT_W = WIDTH + 2;
    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_q;
    logic [OUT_W-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic [1:0]       rem_q;
    logic             err_q;

    logic [OUT_W-1:0] prod_d;
    logic [1:0]       rem_d;
    logic             fire;

    // One step of the MSB-first remainder recurrence: r' = (2r + b) mod 3.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [2:0] v;
        logic [2:0] w;
        v = {r, 1'b0} + {2'b00, b};
        w = v - 3'd3;
        return (v >= 3'd3) ? w[1:0] : v[1:0];
    endfunction

    assign prod_d      = {2'b00, in_data} + {1'b0, in_data, 1'b0};
    assign rem_d       = mod3_step(rem_q, bit_out);
    assign in_ready    = (state_q == IDLE) && !reset;
    assign fire        = in_valid && in_ready;
    assign bit_out     = shreg_q[OUT_W-1];
    assign bit_valid   = (state_q == SHIFT) && tx_en;
    assign frame_start = bit_valid && (cnt_q == CNT_W'(OUT_W));
    assign frame_last  = bit_valid && (cnt_q == CNT_W'(1));
    assign rem_out     = rem_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            rem_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        shreg_q <= prod_d;
                        cnt_q   <= CNT_W'(OUT_W);
                        rem_q   <= 2'd0;
                        gap_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Stalled cycles (tx_en=0) hold shreg, cnt and remainder untouched.
                    if (tx_en) begin
                        shreg_q <= shreg_q << 1;
                        cnt_q   <= cnt_q - CNT_W'(1);
                        rem_q   <= rem_d;
                        if (cnt_q == CNT_W'(1)) begin
                            err_q <= (rem_d != 2'd0);
                            if (GAP_CYCLES == 0) state_q <= IDLE;
                            else                 state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mult3_tx.sv
// Directed bench for serial_mult3_tx: table of words with hand-computed 3x products,
// plus back-to-back handshake and mid-frame reset sequences.
module tb_serial_mult3_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       tx_en;
    logic       bit_out;
    logic       bit_valid;
    logic       frame_start;
    logic       frame_last;
    logic [1:0] rem_out;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    serial_mult3_tx #(.WIDTH(8), .GAP_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx_en(tx_en), .bit_out(bit_out), .bit_valid(bit_valid),
        .frame_start(frame_start), .frame_last(frame_last), .rem_out(rem_out),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] bits;
        bit         stall;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rem_model(input logic [1:0] r, input logic b);
        int v;
        v = (2 * int'(r) + int'(b)) % 3;
        return v[1:0];
    endfunction

    // Entered and left at posedge+1.
    task automatic run_frame(input logic [7:0] d, input logic [9:0] exp, input bit stall);
        int i, n, busy_cnt, exp_busy;
        logic [1:0] rm;
        logic done;
        in_valid = 1'b1;
        in_data  = d;
        tx_en    = 1'b0;
        @(negedge clk);
        check("ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        i = 0; n = 0; busy_cnt = 0; rm = 2'd0; done = 1'b0;
        while (!done && n < 60) begin
            tx_en = stall ? (n % 2 == 0) : 1'b1;
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (in_ready) check("ready_while_busy", in_ready, 0);
                if (frame_err) check("frame_err", frame_err, 0);
                if (bit_valid) begin
                    if (i < 10) begin
                        check($sformatf("bit%0d", i), bit_out, exp[9-i]);
                        check($sformatf("start%0d", i), frame_start, (i == 0));
                        check($sformatf("last%0d", i), frame_last, (i == 9));
                        check($sformatf("rem%0d", i), rem_out, rm);
                        if (stall) check($sformatf("bitpos%0d", i), n, 2 * i);
                        rm = rem_model(rm, exp[9-i]);
                        i++;
                    end else begin
                        check("extra_bit", bit_valid, 0);
                    end
                end else if (i < 10) begin
                    check("valid_follows_tx_en", tx_en, 0);
                    if (i > 0) check($sformatf("hold%0d", i), bit_out, exp[9-i]);
                    if (frame_start || frame_last) check("frame_pulse_unqualified", 1, 0);
                end
            end else begin
                done = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        exp_busy = (stall ? 19 : 10) + 1;
        check("done_in_time", done, 1);
        check("bit_count", i, 10);
        check("busy_cycles", busy_cnt, exp_busy);
        check("rem_final", rem_out, 0);
        check("ready_after", in_ready, 1);
        tx_en = 1'b0;
    endtask

    initial begin
        logic [19:0] got;
        int c, nb, acc, acc1, acc2, starts, viol;
        logic acc_now, fin;

        vecs[0] = '{d: 8'h05, bits: 10'b0000001111, stall: 1'b0};
        vecs[1] = '{d: 8'hFF, bits: 10'b1011111101, stall: 1'b0};
        vecs[2] = '{d: 8'h00, bits: 10'b0000000000, stall: 1'b0};
        vecs[3] = '{d: 8'hA3, bits: 10'b0111101001, stall: 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; tx_en = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rem", rem_out, 0);
        check("rst_frame_err", frame_err, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) run_frame(vecs[k].d, vecs[k].bits, vecs[k].stall);

        // Back-to-back words with in_valid held high.
        in_valid = 1'b1; in_data = 8'h05; tx_en = 1'b1;
        got = '0; c = 0; nb = 0; acc = 0; acc1 = 0; acc2 = 0; starts = 0; viol = 0; fin = 1'b0;
        while (!fin && c < 80) begin
            @(negedge clk);
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                if (acc == 0) acc1 = c; else acc2 = c;
                acc++;
            end
            if (busy && in_ready) viol++;
            if (bit_valid && nb < 20) begin
                got[19-nb] = bit_out;
                nb++;
            end
            if (bit_valid && frame_start) starts++;
            if (acc == 2 && nb == 20 && !busy && !in_valid) fin = 1'b1;
            @(posedge clk); #1;
            if (acc_now) begin
                if (acc == 1) in_data = 8'hFF; else in_valid = 1'b0;
            end
            c++;
        end
        check("b2b_done", fin, 1);
        check("b2b_accepts", acc, 2);
        check("b2b_spacing", acc2 - acc1, 12);
        check("b2b_bits", got, 20'b0000001111_1011111101);
        check("b2b_starts", starts, 2);
        check("b2b_ready_violations", viol, 0);
        tx_en = 1'b0;

        // Reset in the middle of a frame.
        in_valid = 1'b1; in_data = 8'hFF; tx_en = 1'b1;
        @(negedge clk);
        check("mr_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mr_valid_before", bit_valid, 1);
        check("mr_rem_before", rem_out, 2);
        reset = 1'b1;
        #1;
        check("mr_valid_async", bit_valid, 0);
        check("mr_rem_async", rem_out, 0);
        check("mr_busy_async", busy, 0);
        check("mr_ready_in_reset", in_ready, 0);
        check("mr_last", frame_last, 0);
        @(posedge clk); #1;
        check("mr_err", frame_err, 0);
        @(negedge clk); reset = 1'b0;
        #1;
        check("mr_ready_release", in_ready, 1);
        @(posedge clk); #1;
        check("mr_err_after", frame_err, 0);
        run_frame(8'h05, 10'b0000001111, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
